signal_timer: RTL and testbench

SIGNAL_TIMER -- requirements
Module: signal_timer

---
 rtl/signal_timer_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 25 ++
 rtl/signal_timer.sv | 146 ++++++++++++++
 tb/tb_signal_timer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/signal_timer_pkg.sv
// Shared types for the signal timer: measurement modes, FSM states, ncyc width.
package signal_timer_pkg;
  localparam int NCYC_W = 4;

  typedef enum logic [1:0] {
    MODE_PERIOD     = 2'b00,
    MODE_HIGH       = 2'b01,
    MODE_LOW        = 2'b10,
    MODE_PERIOD_ALT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_e;
endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for the measured signal plus a delay flop for edge detection.
module sync_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic si,
  output logic rise,
  output logic fall
);
  logic s_meta, s, s_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      s_d    <= 1'b0;
    end else begin
      s_meta <= si;
      s      <= s_meta;
      s_d    <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
endmodule

// File: rtl/signal_timer.sv
// Measures period / high width / low width of an asynchronous signal in time units,
// with saturation, optional timeout and synchronous abort.
module signal_timer
  import signal_timer_pkg::*;
#(
  parameter int CLK_UNIT_COUNT = 100000,
  parameter int PRD_W          = 16,
  parameter int TMO_UNITS      = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              clr,
  input  logic [1:0]        mode,
  input  logic [NCYC_W-1:0] ncyc,
  input  logic              si,
  output logic              ready,
  output logic              done_tick,
  output logic [PRD_W-1:0]  prd,
  output logic              ovf,
  output logic              tmo
);
  localparam int T_W   = (CLK_UNIT_COUNT > 1) ? $clog2(CLK_UNIT_COUNT) : 1;
  localparam int TMO_W = (TMO_UNITS > 0) ? $clog2(TMO_UNITS + 1) : 1;
  // The start-edge cycle is itself the first cycle of the interval, so an
  // interval of N cycles yields floor(N / CLK_UNIT_COUNT) units.
  localparam logic [T_W-1:0]   T_INIT = (CLK_UNIT_COUNT == 1) ? '0 : T_W'(1);
  localparam logic [PRD_W-1:0] P_INIT = (CLK_UNIT_COUNT == 1) ? PRD_W'(1) : '0;

  state_e             state, state_n;
  mode_e              mode_q;
  logic [NCYC_W-1:0]  ncyc_q, ecnt;
  logic [T_W-1:0]     t;
  logic [PRD_W-1:0]   p;
  logic [TMO_W-1:0]   tcnt;
  logic               ovf_f, tmo_f;
  logic               rise, fall;
  logic               unit_wrap, tmo_hit, start_edge, term_edge;

  sync_edge_det u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .si      (si),
    .rise    (rise),
    .fall    (fall)
  );

  assign unit_wrap  = (t == T_W'(CLK_UNIT_COUNT - 1));
  assign tmo_hit    = (TMO_UNITS != 0) && (tcnt == TMO_W'(TMO_UNITS));
  assign start_edge = (mode_q == MODE_LOW) ? fall : rise;
  assign ready      = (state == IDLE);

  always_comb begin
    term_edge = 1'b0;
    case (mode_q)
      MODE_HIGH: term_edge = fall;
      MODE_LOW:  term_edge = rise;
      default:   term_edge = rise && (ecnt == ncyc_q - 1'b1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = ARM;
      ARM:  if (start_edge) state_n = MEAS;
            else if (tmo_hit) state_n = DONE;
      MEAS: if (term_edge || tmo_hit) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clr) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q    <= MODE_PERIOD;
      ncyc_q    <= NCYC_W'(1);
      ecnt      <= '0;
      t         <= '0;
      p         <= '0;
      tcnt      <= '0;
      ovf_f     <= 1'b0;
      tmo_f     <= 1'b0;
      prd       <= '0;
      ovf       <= 1'b0;
      tmo       <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      if ((state == ARM || state == MEAS) && unit_wrap && !tmo_hit) tcnt <= tcnt + 1'b1;
      case (state)
        IDLE: begin
          t    <= '0;
          tcnt <= '0;
          if (start) begin
            mode_q <= mode_e'(mode);
            ncyc_q <= (ncyc == '0) ? NCYC_W'(1) : ncyc;
            p      <= '0;
            ovf_f  <= 1'b0;
            tmo_f  <= 1'b0;
          end
        end
        ARM: begin
          if (start_edge) begin
            t     <= T_INIT;
            p     <= P_INIT;
            ecnt  <= '0;
            ovf_f <= 1'b0;
          end else begin
            t <= unit_wrap ? '0 : t + 1'b1;
            if (tmo_hit) tmo_f <= 1'b1;
          end
        end
        MEAS: begin
          // A terminating edge freezes the count; any partial unit is dropped.
          if (!term_edge) begin
            if (unit_wrap) begin
              t <= '0;
              if (&p) ovf_f <= 1'b1;
              else    p     <= p + 1'b1;
            end else begin
              t <= t + 1'b1;
            end
            if (rise)    ecnt  <= ecnt + 1'b1;
            if (tmo_hit) tmo_f <= 1'b1;
          end
        end
        DONE: begin
          if (!clr) begin
            prd       <= p;
            ovf       <= ovf_f;
            tmo       <= tmo_f;
            done_tick <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_signal_timer.sv
// Bench for signal_timer: three instances (8-bit, 4-bit, no timeout) share one stimulus.
module tb_signal_timer;
  localparam int CU  = 10;
  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       reset_n, start, clr, si;
  logic [1:0] mode;
  logic [3:0] ncyc;
  logic       r8, d8, o8, t8;
  logic [7:0] p8;
  logic       r4, d4, o4, t4;
  logic [3:0] p4;
  logic       rn, dn, ovn, tn;
  logic [7:0] pn;

  int vectors = 0;
  int errors  = 0;
  int dc8 = 0, dc4 = 0, dcn = 0;

  typedef struct {
    logic [1:0] m;
    logic [3:0] n;
    int h, l;
    int e8, et, e4, eo4, en;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  signal_timer #(.CLK_UNIT_COUNT(CU), .PRD_W(8), .TMO_UNITS(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clr(clr), .mode(mode), .ncyc(ncyc),
    .si(si), .ready(r8), .done_tick(d8), .prd(p8), .ovf(o8), .tmo(t8));
  signal_timer #(.CLK_UNIT_COUNT(CU), .PRD_W(4), .TMO_UNITS(TMO)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .clr(clr), .mode(mode), .ncyc(ncyc),
    .si(si), .ready(r4), .done_tick(d4), .prd(p4), .ovf(o4), .tmo(t4));
  signal_timer #(.CLK_UNIT_COUNT(CU), .PRD_W(8), .TMO_UNITS(0)) dutn (
    .clk(clk), .reset_n(reset_n), .start(start), .clr(clr), .mode(mode), .ncyc(ncyc),
    .si(si), .ready(rn), .done_tick(dn), .prd(pn), .ovf(ovn), .tmo(tn));

  always @(negedge clk) begin
    if (d8) dc8++;
    if (d4) dc4++;
    if (dn) dcn++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference: whole units elapsed, saturated to the result width.
  function automatic int sat(input int u, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (u > mx) ? mx : u;
  endfunction

  task automatic measure(input logic [1:0] m, input logic [3:0] n, input int h, input int l);
    int np;
    np = (n == 0) ? 1 : int'(n);
    si = (m == 2'd2);
    repeat (6) tick();
    mode = m; ncyc = n; start = 1'b1;
    tick();
    start = 1'b0;
    mode = 2'($urandom_range(0, 3));
    ncyc = 4'($urandom_range(0, 15));
    repeat (3) tick();
    case (m)
      2'd1: begin si = 1'b1; repeat (h) tick(); si = 1'b0; end
      2'd2: begin si = 1'b0; repeat (l) tick(); si = 1'b1; end
      default: begin
        si = 1'b1;
        for (int i = 0; i < np; i++) begin
          repeat (h) tick(); si = 1'b0;
          repeat (l) tick(); si = 1'b1;
        end
      end
    endcase
    repeat (8) tick();
  endtask

  task automatic apply(input vec_t v);
    int b8, b4, bn;
    b8 = dc8; b4 = dc4; bn = dcn;
    measure(v.m, v.n, v.h, v.l);
    chk("done8_cnt", dc8 - b8, 1);
    chk("done4_cnt", dc4 - b4, 1);
    chk("donen_cnt", dcn - bn, 1);
    if (v.e8 >= 0) chk("prd8", 32'(p8), v.e8);
    chk("ovf8", 32'(o8), 0);
    chk("tmo8", 32'(t8), v.et);
    chk("prd4", 32'(p4), v.e4);
    chk("ovf4", 32'(o4), v.eo4);
    chk("tmo4", 32'(t4), v.et);
    chk("prdn", 32'(pn), v.en);
    chk("ovfn", 32'(ovn), 0);
    chk("tmon", 32'(tn), 0);
    chk("ready8", 32'(r8), 1);
  endtask

  initial begin
    int b8, cyc;
    // {mode, ncyc, high, low, prd8 (-1 = skip), tmo, prd4, ovf4, prd no-timeout}
    tbl[0] = '{2'd0, 4'd1, 125, 125,  25, 0, 15, 1,  25};
    tbl[1] = '{2'd0, 4'd4, 125, 125,  -1, 1, 15, 1, 100};
    tbl[2] = '{2'd1, 4'd0,  73,   0,   7, 0,  7, 0,   7};
    tbl[3] = '{2'd2, 4'd0,   0, 120,  12, 0, 12, 0,  12};
    tbl[4] = '{2'd0, 4'd1, 150, 150,  30, 0, 15, 1,  30};
    tbl[5] = '{2'd3, 4'd0,  60,  40,  10, 0, 10, 0,  10};
    tbl[6] = '{2'd1, 4'd0,   9,   0,   0, 0,  0, 0,   0};
    tbl[7] = '{2'd1, 4'd0,  10,   0,   1, 0,  1, 0,   1};
    tbl[8] = '{2'd2, 4'd0,   0, 159,  15, 0, 15, 0,  15};
    tbl[9] = '{2'd2, 4'd0,   0, 160,  16, 0, 15, 1,  16};

    reset_n = 1'b0; start = 1'b0; clr = 1'b0; si = 1'b0; mode = 2'd0; ncyc = 4'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_ready", 32'(r8), 1);
    chk("rst_done", 32'(d8), 0);
    chk("rst_prd", 32'(p8), 0);
    chk("rst_ovf", 32'(o8), 0);
    chk("rst_tmo", 32'(t8), 0);

    for (int k = 0; k < 10; k++) apply(tbl[k]);

    for (int k = 0; k < 16; k++) begin
      vec_t v;
      int np, nn, u;
      v.m = 2'($urandom_range(0, 3));
      v.n = 4'($urandom_range(0, 3));
      np  = (v.n == 0) ? 1 : int'(v.n);
      v.h = $urandom_range(2, 150 / np);
      v.l = $urandom_range(2, 150 / np);
      case (v.m)
        2'd1:    nn = v.h;
        2'd2:    nn = v.l;
        default: nn = np * (v.h + v.l);
      endcase
      u = nn / CU;
      v.e8 = sat(u, 8); v.et = 0; v.e4 = sat(u, 4); v.eo4 = (u > 15) ? 1 : 0; v.en = sat(u, 8);
      apply(v);
    end

    // start during MEAS must not relatch mode
    b8 = dc8;
    si = 1'b0; repeat (6) tick();
    mode = 2'd1; ncyc = 4'd0; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    si = 1'b1; repeat (20) tick();
    mode = 2'd2; start = 1'b1; tick(); start = 1'b0;
    repeat (52) tick();
    si = 1'b0; repeat (8) tick();
    chk("ign_start_done", dc8 - b8, 1);
    chk("ign_start_prd", 32'(p8), 7);

    // clr mid-MEAS
    b8 = dc8;
    mode = 2'd1; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    si = 1'b1; repeat (40) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ready", 32'(r8), 1);
    si = 1'b0; repeat (10) tick();
    chk("clr_no_done", dc8 - b8, 0);
    chk("clr_prd_hold", 32'(p8), 7);

    // reset mid-MEAS, si high at release
    b8 = dc8;
    mode = 2'd1; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    si = 1'b1; repeat (40) tick();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("mrst_ready", 32'(r8), 1);
    chk("mrst_prd", 32'(p8), 0);
    chk("mrst_ovf4", 32'(o4), 0);
    chk("mrst_tmo", 32'(t8), 0);
    repeat (6) tick();
    si = 1'b0; repeat (10) tick();
    chk("mrst_no_done", dc8 - b8, 0);
    chk("mrst_ready_idle", 32'(r8), 1);

    // timeout with si held constant
    repeat (4) tick();
    mode = 2'd0; ncyc = 4'd1; start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while (cyc < 700 && !d8) begin
      tick();
      cyc++;
    end
    chk("tmo_seen", 32'(d8), 1);
    chk("tmo_latency_ok", 32'(cyc >= 496 && cyc <= 504), 1);
    tick();
    chk("tmo_flag8", 32'(t8), 1);
    chk("tmo_prd8", 32'(p8), 0);
    chk("tmo_flag4", 32'(t4), 1);
    chk("tmo_disabled_waits", 32'(rn), 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_from_arm", 32'(rn), 1);
    chk("clr_keeps_tmo", 32'(tn), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
